// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// Optional MADD/MSUB accumulate ops (op 6/7) are built only when MDU_MADD_EN is defined.
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] result;
  logic               result_we;

  logic             div_signed;
  logic             neg_a;
  logic             neg_b;
  logic             div_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] mag_b_safe;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Sign-extending to 2W before an unsigned multiply yields the exact signed product mod 2^(2W).
  always_comb begin
    prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  end

  // Signed division runs on magnitudes; MIN/-1 wraps back to MIN with zero remainder.
  always_comb begin
    div_signed = (op_q == OP_DIV);
    neg_a      = div_signed & a_q[WIDTH-1];
    neg_b      = div_signed & b_q[WIDTH-1];
    mag_a      = neg_a ? -a_q : a_q;
    mag_b      = neg_b ? -b_q : b_q;
    div_zero   = (b_q == '0);
    mag_b_safe = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    uq         = mag_a / mag_b_safe;
    ur         = mag_a % mag_b_safe;
    quot       = (neg_a ^ neg_b) ? -uq : uq;
    rem        = neg_a ? -ur : ur;
  end

  always_comb begin
    result    = {hi, lo};
    result_we = 1'b1;
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV, OP_DIVU: begin
        result    = {rem, quot};
        result_we = !div_zero;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi, lo} + prod_s;
      OP_MSUB:  result = {hi, lo} - prod_s;
`endif
      default:  result_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
                cnt   <= MUL_LOAD;
                state <= RUN;
                busy  <= 1'b1;
              end
`ifdef MDU_MADD_EN
              OP_MADD, OP_MSUB: begin
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
                cnt   <= MUL_LOAD;
                state <= RUN;
                busy  <= 1'b1;
              end
`endif
              OP_DIV, OP_DIVU: begin
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
                cnt   <= DIV_LOAD;
                state <= RUN;
                busy  <= 1'b1;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          // New requests are dropped here; the pipeline is expected to stall on busy.
          if (cnt == '0) begin
            if (result_we) begin
              hi <= result[2*WIDTH-1:WIDTH];
              lo <= result[WIDTH-1:0];
            end
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - vector table and scoreboard bench for mul_div_unit
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  mul_div_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic compare_next(input string tag, input int n);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got result with empty scoreboard expected queued entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".busy_cycles"}, 32'(n), 32'(e.lat));
      chk({tag, ".hi"}, hi, e.hi);
      chk({tag, ".lo"}, lo, e.lo);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    drive(OP_MTHI, v.pre_hi, 32'h0);
    drive(OP_MTLO, v.pre_lo, 32'h0);
    sb.push_back('{v.exp_hi, v.exp_lo, v.lat});
    drive(v.op, v.a, v.b);
    wait_done(n);
    compare_next(tag, n);
  endtask

  initial begin
    int n;

    //           op        a             b             pre_hi  pre_lo   exp_hi        exp_lo        lat
    vecs.push_back('{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    vecs.push_back('{OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h0,  32'h0,  32'h00000002, 32'hFFFFFFFA, 5});
    vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h0,  32'h0,  32'h40000000, 32'h00000000, 5});
    vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,  32'hFFFFFFFE, 32'h00000001, 5});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,  32'h00000000, 32'h80000000, 10});
    vecs.push_back('{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0,  32'h0,  32'h00000001, 32'hFFFFFFFD, 10});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF8, 32'h00000003, 32'h0,  32'h0,  32'hFFFFFFFE, 32'hFFFFFFFE, 10});
    vecs.push_back('{OP_DIVU,  32'h00000064, 32'h00000007, 32'h0,  32'h0,  32'h00000002, 32'h0000000E, 10});
    vecs.push_back('{OP_DIVU,  32'h00000007, 32'h00000000, 32'h11, 32'h22, 32'h00000011, 32'h00000022, 10});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'h33, 32'h44, 32'h00000033, 32'h00000044, 10});
    vecs.push_back('{OP_MTLO,  32'h00001234, 32'h0,        32'h99, 32'h55, 32'h00000099, 32'h00001234, 0});
    vecs.push_back('{OP_MTHI,  32'h0000CAFE, 32'h0,        32'h1,  32'h2,  32'h0000CAFE, 32'h00000002, 0});
`ifdef MDU_MADD_EN
    vecs.push_back('{OP_MADD,  32'h00000002, 32'h00000003, 32'h0,  32'h10, 32'h00000000, 32'h00000016, 5});
    vecs.push_back('{OP_MADD,  32'hFFFFFFFF, 32'h00000005, 32'h0,  32'h10, 32'h00000000, 32'h0000000B, 5});
    vecs.push_back('{OP_MSUB,  32'h00000002, 32'h00000003, 32'h0,  32'h2,  32'hFFFFFFFF, 32'hFFFFFFFC, 5});
`else
    vecs.push_back('{OP_MADD,  32'h00000002, 32'h00000003, 32'h0,  32'h10, 32'h00000000, 32'h00000010, 0});
    vecs.push_back('{OP_MSUB,  32'h00000002, 32'h00000003, 32'h0,  32'h2,  32'h00000000, 32'h00000002, 0});
`endif

    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'h0;
    b     = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset.busy", {31'h0, busy}, 32'h0);
    chk("reset.hi", hi, 32'h0);
    chk("reset.lo", lo, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Requests arriving during a MULT (MTHI and DIVU) must be dropped.
    drive(OP_MTHI, 32'h0000AAAA, 32'h0);
    drive(OP_MTLO, 32'h0000BBBB, 32'h0);
    sb.push_back('{32'h0, 32'd42, 5});
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd6;
    b     = 32'd7;
    @(negedge clk);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy === 1'b1) n++;
      start = (k < 4);
      op    = (k % 2 == 1) ? OP_DIVU : OP_MTHI;
      a     = 32'h00005555;
      b     = 32'h1;
      @(negedge clk);
    end
    start = 1'b0;
    compare_next("busy_ignore", n);

    // Asynchronous reset in the third busy cycle of a DIV.
    drive(OP_MTHI, 32'h77, 32'h0);
    drive(OP_MTLO, 32'h88, 32'h0);
    drive(OP_DIV, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    chk("abort.busy_before", {31'h0, busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort.busy", {31'h0, busy}, 32'h0);
    chk("abort.hi", hi, 32'h0);
    chk("abort.lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort.busy_late", {31'h0, busy}, 32'h0);
    chk("abort.hi_late", hi, 32'h0);
    chk("abort.lo_late", lo, 32'h0);

    // Unit must accept work again after the abort.
    run_vec('{OP_MULTU, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h00000001, 32'h00000000, 5}, "post_abort");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
